// File: rtl/image_io_ctrl.sv
// image_io_ctrl: host-side sequencer for the downsampling processor.
// Streams an input image into the shared RAM, hands the RAM to the processor,
// then reads the result back out through a 2-entry buffer onto a byte stream.
// Optional feature macro: IMAGE_IO_CHECKSUM_EN (16-bit sum of drained bytes).
module image_io_ctrl #(
   parameter logic [15:0] IN_BASE  = 16'h0000,
   parameter int unsigned IN_LEN   = 16384,
   parameter logic [15:0] OUT_BASE = 16'h4000,
   parameter int unsigned OUT_LEN  = 4096
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic [7:0]  m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic        proc_enable,
   input  logic        proc_finish,
   input  logic [15:0] proc_addr,
   input  logic [7:0]  proc_dout,
   input  logic        proc_read,
   input  logic        proc_write,
   output logic [7:0]  proc_din,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_we,
   output logic        mem_re,
   input  logic [7:0]  mem_rdata,
   output logic        busy,
   output logic        done,
   output logic [15:0] checksum
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE
   } state_e;

   // 17-bit counts so a full 64 KiB transfer can be expressed.
   localparam logic [16:0] IN_LEN_C   = 17'(IN_LEN);
   localparam logic [16:0] OUT_LEN_C  = 17'(OUT_LEN);
   localparam logic [16:0] OUT_LAST_C = 17'(OUT_LEN - 1);

   state_e      state_q, state_d;
   logic [16:0] cnt_q, cnt_d;          // load handshakes / drain reads issued
   logic [16:0] pop_cnt_q, pop_cnt_d;  // drain bytes delivered
   logic        wr_valid_q, wr_valid_d;
   logic [15:0] wr_addr_q, wr_addr_d;
   logic [7:0]  wr_data_q, wr_data_d;
   logic        rd_pend_q, rd_pend_d;  // a RAM read returns data this cycle
   logic [7:0]  buf_q [2];
   logic        wr_ptr_q, wr_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  occ_q, occ_d;

   logic        s_hs;
   logic        pop;
   logic        rd_issue;
   logic [2:0]  occ_sum;

   assign proc_din = mem_rdata;

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of block evaluation order.
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default assignment first so no path through the case infers a latch.
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_LOAD;
         S_LOAD:  if (cnt_q == IN_LEN_C) state_d = S_RUN;
         S_RUN:   if (proc_finish) state_d = S_DRAIN;
         S_DRAIN: if (pop && (pop_cnt_q == OUT_LAST_C)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs, RAM port mux and handshake strobes decoded from the state.
   always_comb begin
      s_ready     = 1'b0;
      m_valid     = 1'b0;
      m_data      = 8'h00;
      proc_enable = 1'b0;
      mem_addr    = 16'h0000;
      mem_wdata   = 8'h00;
      mem_we      = 1'b0;
      mem_re      = 1'b0;
      done        = 1'b0;
      busy        = (state_q != S_IDLE);
      s_hs        = 1'b0;
      pop         = 1'b0;
      rd_issue    = 1'b0;
      occ_sum     = 3'd0;
      case (state_q)
         S_LOAD: begin
            s_ready   = (cnt_q != IN_LEN_C);
            s_hs      = s_valid && s_ready;
            mem_we    = wr_valid_q;
            mem_addr  = wr_addr_q;
            mem_wdata = wr_data_q;
         end
         S_RUN: begin
            proc_enable = 1'b1;
            mem_addr    = proc_addr;
            mem_wdata   = proc_dout;
            mem_we      = proc_write;
            mem_re      = proc_read;
         end
         S_DRAIN: begin
            m_valid  = (occ_q != 2'd0);
            m_data   = m_valid ? buf_q[rd_ptr_q] : 8'h00;
            pop      = m_valid && m_ready;
            // Occupancy after this cycle, counting the read still in flight.
            occ_sum  = {1'b0, occ_q} + {2'b00, rd_pend_q} - {2'b00, pop};
            rd_issue = (cnt_q != OUT_LEN_C) && (occ_sum < 3'd2);
            mem_re   = rd_issue;
            mem_addr = OUT_BASE + cnt_q[15:0];
         end
         S_DONE: done = 1'b1;
         default: ;
      endcase
   end

   // Datapath next-state: counters, registered load write, buffer pointers.
   always_comb begin
      cnt_d      = cnt_q;
      pop_cnt_d  = pop_cnt_q;
      wr_valid_d = s_hs;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      rd_pend_d  = rd_issue;
      wr_ptr_d   = rd_pend_q ? ~wr_ptr_q : wr_ptr_q;
      rd_ptr_d   = pop ? ~rd_ptr_q : rd_ptr_q;
      occ_d      = occ_q + {1'b0, rd_pend_q} - {1'b0, pop};
      case (state_q)
         S_IDLE: if (start) cnt_d = 17'd0;
         S_LOAD: begin
            if (s_hs) begin
               cnt_d     = cnt_q + 17'd1;
               wr_addr_d = IN_BASE + cnt_q[15:0];
               wr_data_d = s_data;
            end
         end
         S_RUN: begin
            if (proc_finish) begin
               cnt_d     = 17'd0;
               pop_cnt_d = 17'd0;
            end
         end
         S_DRAIN: begin
            if (rd_issue) cnt_d = cnt_q + 17'd1;
            if (pop) pop_cnt_d = pop_cnt_q + 17'd1;
         end
         default: ;
      endcase
   end

   // Control registers; reset discards the buffer contents and in-flight read.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q      <= 17'd0;
         pop_cnt_q  <= 17'd0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= 16'h0000;
         wr_data_q  <= 8'h00;
         rd_pend_q  <= 1'b0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         occ_q      <= 2'd0;
      end else begin
         cnt_q      <= cnt_d;
         pop_cnt_q  <= pop_cnt_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         rd_pend_q  <= rd_pend_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         occ_q      <= occ_d;
      end
   end

   // Buffer storage captures RAM read data one cycle after the read strobe.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; occupancy is, and m_data is gated by m_valid.
      if (rd_pend_q) buf_q[wr_ptr_q] <= mem_rdata;
   end

`ifdef IMAGE_IO_CHECKSUM_EN
   logic [15:0] chk_q, chk_d;

   // Running sum of delivered bytes, cleared when a job starts loading.
   always_comb begin
      chk_d = chk_q;
      if ((state_q == S_IDLE) && start) chk_d = 16'h0000;
      else if (pop)                     chk_d = chk_q + {8'h00, m_data};
   end

   // Checksum register.
   always_ff @(posedge clk) begin
      if (!rst_n) chk_q <= 16'h0000;
      else        chk_q <= chk_d;
   end

   assign checksum = chk_q;
`else
   assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_image_io_ctrl.sv
// Bench for image_io_ctrl: directed jobs with a RAM model and a stub processor.
// Expected writes and output bytes go into queues; negedge monitors compare.
module tb_image_io_ctrl;

   localparam logic [15:0] IN_BASE  = 16'h0000;
   localparam logic [15:0] OUT_BASE = 16'h4000;
   localparam int          IN_LEN   = 16;
   localparam int          OUT_LEN  = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  s_data = 8'h00;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic        proc_enable;
   logic        proc_finish = 1'b0;
   logic [15:0] proc_addr = 16'h0000;
   logic [7:0]  proc_dout = 8'h00;
   logic        proc_read = 1'b0;
   logic        proc_write = 1'b0;
   logic [7:0]  proc_din;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [7:0]  mem_rdata = 8'h00;
   logic        busy;
   logic        done;
   logic [15:0] checksum;

   image_io_ctrl #(
      .IN_BASE(IN_BASE), .IN_LEN(IN_LEN), .OUT_BASE(OUT_BASE), .OUT_LEN(OUT_LEN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .proc_enable(proc_enable), .proc_finish(proc_finish),
      .proc_addr(proc_addr), .proc_dout(proc_dout),
      .proc_read(proc_read), .proc_write(proc_write), .proc_din(proc_din),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_re(mem_re), .mem_rdata(mem_rdata),
      .busy(busy), .done(done), .checksum(checksum)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: write on we, read data one cycle after re; bench preload port.
   logic [7:0]  ram [0:65535];
   logic        pre_we = 1'b0;
   logic [15:0] pre_addr = 16'h0000;
   logic [7:0]  pre_data = 8'h00;
   always @(posedge clk) begin
      if (mem_we)      ram[mem_addr] <= mem_wdata;
      else if (pre_we) ram[pre_addr] <= pre_data;
      if (mem_re) mem_rdata <= ram[mem_addr];
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [15:0] exp_sum(input logic [15:0] s);
`ifdef IMAGE_IO_CHECKSUM_EN
      return s;
`else
      return (s & 16'h0000);
`endif
   endfunction

   // Scoreboard queues and monitor bookkeeping.
   logic [23:0] wr_exp [$];
   logic [7:0]  exp_q [$];
   int          wr_cyc [$];
   int          pop_cyc [$];
   int          first_valid_cyc = -1;
   bit          prev_stall = 1'b0;
   logic [7:0]  held = 8'h00;

   // Monitor: RAM writes, RAM ownership during RUN, stall stability, output bytes.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid_hold", 32'(m_valid), 32'd1);
            check("stall_data_hold", 32'(m_data), 32'(held));
         end
         if (mem_we) begin
            check("write_expected", 32'(wr_exp.size() != 0), 32'd1);
            if (wr_exp.size() != 0) begin
               logic [23:0] e;
               e = wr_exp.pop_front();
               check("write_addr", 32'(mem_addr), 32'(e[23:8]));
               check("write_data", 32'(mem_wdata), 32'(e[7:0]));
            end
            wr_cyc.push_back(cyc);
         end
         if (proc_enable) begin
            check("run_owner_we", 32'(mem_we), 32'(proc_write));
            check("run_owner_re", 32'(mem_re), 32'(proc_read));
         end
         if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (m_valid && m_ready) begin
            check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("m_data", 32'(m_data), 32'(exp_q.pop_front()));
            pop_cyc.push_back(cyc);
         end
         prev_stall = m_valid && !m_ready;
         held       = m_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload_out(input logic [7:0] b0);
      logic [7:0] vals [4];
      vals = '{b0, 8'h02, 8'h03, 8'h04};
      for (int k = 0; k < 4; k++) begin
         pre_we   = 1'b1;
         pre_addr = OUT_BASE + 16'(k);
         pre_data = vals[k];
         tick();
      end
      pre_we = 1'b0;
   endtask

   // One job: load 0x00..0x0F, optional stub write of 0xAA to OUT_BASE,
   // then drain four bytes (or reset part-way through the drain).
   task automatic run_job(input bit stub, input bit toggle, input bit abort,
                          input logic [7:0] b0, input logic [15:0] sum);
      bit got_done;
      int drain_start;
      preload_out(8'h01);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("load_busy", 32'(busy), 32'd1);
      check("load_ready", 32'(s_ready), 32'd1);
      check("load_clears_sum", 32'(checksum), 32'd0);
      wr_cyc.delete();
      for (int i = 0; i < IN_LEN; i++) begin
         s_data  = 8'(i);
         s_valid = 1'b1;
         wr_exp.push_back({IN_BASE + 16'(i), 8'(i)});
         tick();
      end
      s_valid = 1'b0;
      check("load_ready_drop", 32'(s_ready), 32'd0);
      check("load_no_enable", 32'(proc_enable), 32'd0);
      tick();
      check("run_enable", 32'(proc_enable), 32'd1);
      check("load_write_count", 32'(wr_cyc.size()), 32'(IN_LEN));
      if (wr_cyc.size() == IN_LEN)
         check("load_write_span", 32'(wr_cyc[IN_LEN-1] - wr_cyc[0]), 32'(IN_LEN - 1));
      // RUN: stub processor, plus a start pulse that must be ignored.
      if (stub) begin
         proc_addr  = OUT_BASE;
         proc_dout  = 8'hAA;
         proc_write = 1'b1;
         start      = 1'b1;
         wr_exp.push_back({OUT_BASE, 8'hAA});
         #1;
         check("run_mux_addr", 32'(mem_addr), 32'(OUT_BASE));
         check("run_mux_we", 32'(mem_we), 32'd1);
         tick();
         proc_write = 1'b0;
         start      = 1'b0;
      end
      proc_addr = 16'h1234;
      check("run_no_ready", 32'(s_ready), 32'd0);
      tick();
      check("run_enable_steady", 32'(proc_enable), 32'd1);
      proc_finish = 1'b1;
      tick();
      proc_finish = 1'b0;
      // First DRAIN cycle.
      drain_start     = cyc;
      first_valid_cyc = -1;
      pop_cyc.delete();
      check("finish_enable_drop", 32'(proc_enable), 32'd0);
      check("drain_first_re", 32'(mem_re), 32'd1);
      check("drain_first_addr", 32'(mem_addr), 32'(OUT_BASE));
      s_valid = 1'b1;
      s_data  = 8'h55;
      check("drain_no_ready", 32'(s_ready), 32'd0);
      if (abort) begin
         m_ready = 1'b0;
         repeat (3) tick();
         check("abort_pre_valid", 32'(m_valid), 32'd1);
         rst_n = 1'b0;
         tick();
         check("abort_busy", 32'(busy), 32'd0);
         check("abort_valid", 32'(m_valid), 32'd0);
         check("abort_enable", 32'(proc_enable), 32'd0);
         check("abort_re", 32'(mem_re), 32'd0);
         check("abort_checksum", 32'(checksum), 32'd0);
         rst_n   = 1'b1;
         s_valid = 1'b0;
         tick();
         check("abort_idle_busy", 32'(busy), 32'd0);
         return;
      end
      exp_q.push_back(b0);
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h03);
      exp_q.push_back(8'h04);
      got_done = 1'b0;
      for (int k = 0; k < 200; k++) begin
         m_ready = toggle ? ((k % 4) == 0 || (k % 4) == 3) : 1'b1;
         tick();
         if (done) begin
            got_done = 1'b1;
            break;
         end
      end
      s_valid = 1'b0;
      check("done_seen", 32'(got_done), 32'd1);
      check("drain_all_popped", 32'(exp_q.size()), 32'd0);
      check("first_valid_latency", 32'(first_valid_cyc - drain_start), 32'd2);
      if (!toggle && pop_cyc.size() == OUT_LEN)
         check("drain_back_to_back", 32'(pop_cyc[OUT_LEN-1] - pop_cyc[0]), 32'(OUT_LEN - 1));
      check("done_checksum", 32'(checksum), 32'(exp_sum(sum)));
      check("done_busy", 32'(busy), 32'd1);
      tick();
      check("done_single", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_checksum_hold", 32'(checksum), 32'(exp_sum(sum)));
      exp_q.delete();
   endtask

   initial begin
      rst_n = 1'b0;
      tick();
      tick();
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_valid", 32'(m_valid), 32'd0);
      check("reset_m_data", 32'(m_data), 32'd0);
      check("reset_enable", 32'(proc_enable), 32'd0);
      check("reset_we", 32'(mem_we), 32'd0);
      check("reset_re", 32'(mem_re), 32'd0);
      check("reset_checksum", 32'(checksum), 32'd0);
      check("reset_ready", 32'(s_ready), 32'd0);
      rst_n = 1'b1;
      tick();
      // Stub overwrites the first output byte: 0xAA+2+3+4 = 0xB3.
      run_job(1'b1, 1'b0, 1'b0, 8'hAA, 16'h00B3);
      // Plain drain of 1,2,3,4: sum 10.
      run_job(1'b0, 1'b0, 1'b0, 8'h01, 16'd10);
      // m_ready toggling 1,0,0,1,...
      run_job(1'b0, 1'b1, 1'b0, 8'h01, 16'd10);
      // Reset in the middle of DRAIN, then a clean job.
      run_job(1'b0, 1'b0, 1'b1, 8'h01, 16'd10);
      run_job(1'b0, 1'b0, 1'b0, 8'h01, 16'd10);
      check("writes_all_seen", 32'(wr_exp.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
